vga_pixel_pipe: RTL and testbench



---
 rtl/vga_pixel_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// Pixel stage behind the VGA sync generator: 32x32 tile background
// plus one 32x32 sprite, five-clock pipeline with aligned syncs.
module vga_pixel_pipe #(
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [9:0]  col_in,
  input  logic [9:0]  row_in,
  input  logic        in_screen,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  spr_x,
  input  logic [9:0]  spr_y,
  input  logic [1:0]  spr_frame,
  input  logic        spr_en,
  output logic [8:0]  map_addr,
  input  logic [5:0]  map_data,
  output logic [15:0] tile_addr,
  input  logic [11:0] tile_data,
  output logic [11:0] spr_addr,
  input  logic [11:0] spr_data,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  logic [9:0]  sx_q, sx_d, sy_q, sy_d;
  logic [1:0]  sframe_q, sframe_d;
  logic        sen_q, sen_d;
  logic        vs_prev_q, vs_prev_d;
  logic        frame_tick_q, frame_tick_d;

  logic [8:0]  map_addr_q, map_addr_d;
  logic [11:0] spr_addr_q, spr_addr_d;
  logic [4:0]  tx1_q, tx1_d, ty1_q, ty1_d;
  logic        hit1_q, hit1_d, blank1_q, blank1_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;

  logic [4:0]  tx2_q, tx2_d, ty2_q, ty2_d;
  logic        hit2_q, hit2_d, blank2_q, blank2_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;

  logic [15:0] tile_addr_q, tile_addr_d;
  logic [11:0] spr3_q, spr3_d;
  logic        hit3_q, hit3_d, blank3_q, blank3_d;
  logic        hs3_q, hs3_d, vs3_q, vs3_d;

  logic [11:0] spr4_q, spr4_d;
  logic        hit4_q, hit4_d, blank4_q, blank4_d;
  logic        hs4_q, hs4_d, vs4_q, vs4_d;

  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;

  logic        vs_rise, hit;
  logic [10:0] c11, r11, sx11, sy11;
  logic [8:0]  trow, tcol;
  logic [4:0]  sdx, sdy;

  always_comb begin
    vs_rise      = vsync_in & ~vs_prev_q;
    vs_prev_d    = vsync_in;
    frame_tick_d = vs_rise;
    sx_d         = sx_q;
    sy_d         = sy_q;
    sframe_d     = sframe_q;
    sen_d        = sen_q;
    if (vs_rise) begin
      sx_d     = spr_x;
      sy_d     = spr_y;
      sframe_d = spr_frame;
      sen_d    = spr_en;
    end

    // 11-bit compare so a sprite near the edge clips instead of wrapping
    c11  = {1'b0, col_in};
    r11  = {1'b0, row_in};
    sx11 = {1'b0, sx_q};
    sy11 = {1'b0, sy_q};
    hit  = sen_q & in_screen
         & (c11 >= sx11) & (c11 < sx11 + 11'd32)
         & (r11 >= sy11) & (r11 < sy11 + 11'd32);
    sdx  = col_in[4:0] - sx_q[4:0];
    sdy  = row_in[4:0] - sy_q[4:0];

    // tr*25 + tc as shifts and adds
    trow = {4'd0, row_in[9:5]};
    tcol = {4'd0, col_in[9:5]};

    map_addr_d = in_screen ? (trow << 4) + (trow << 3) + trow + tcol
                           : 9'd0;
    spr_addr_d = in_screen ? {sframe_q, sdy, sdx} : 12'd0;
    tx1_d      = col_in[4:0];
    ty1_d      = row_in[4:0];
    hit1_d     = hit;
    blank1_d   = ~in_screen;
    hs1_d      = hsync_in;
    vs1_d      = vsync_in;

    tx2_d      = tx1_q;
    ty2_d      = ty1_q;
    hit2_d     = hit1_q;
    blank2_d   = blank1_q;
    hs2_d      = hs1_q;
    vs2_d      = vs1_q;

    tile_addr_d = {map_data, ty2_q, tx2_q};
    spr3_d      = spr_data;
    hit3_d      = hit2_q;
    blank3_d    = blank2_q;
    hs3_d       = hs2_q;
    vs3_d       = vs2_q;

    spr4_d      = spr3_q;
    hit4_d      = hit3_q;
    blank4_d    = blank3_q;
    hs4_d       = hs3_q;
    vs4_d       = vs3_q;

    rgb_d = tile_data;
    if (blank4_q)
      rgb_d = 12'h000;
    else if (hit4_q && spr4_q != TRANSPARENT)
      rgb_d = spr4_q;
    hsync_d = hs4_q;
    vsync_d = vs4_q;
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      sx_q         <= '0;
      sy_q         <= '0;
      sframe_q     <= '0;
      sen_q        <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      map_addr_q   <= '0;
      spr_addr_q   <= '0;
      tx1_q        <= '0;
      ty1_q        <= '0;
      hit1_q       <= 1'b0;
      blank1_q     <= 1'b1;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      tx2_q        <= '0;
      ty2_q        <= '0;
      hit2_q       <= 1'b0;
      blank2_q     <= 1'b1;
      hs2_q        <= 1'b0;
      vs2_q        <= 1'b0;
      tile_addr_q  <= '0;
      spr3_q       <= '0;
      hit3_q       <= 1'b0;
      blank3_q     <= 1'b1;
      hs3_q        <= 1'b0;
      vs3_q        <= 1'b0;
      spr4_q       <= '0;
      hit4_q       <= 1'b0;
      blank4_q     <= 1'b1;
      hs4_q        <= 1'b0;
      vs4_q        <= 1'b0;
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      sframe_q     <= sframe_d;
      sen_q        <= sen_d;
      vs_prev_q    <= vs_prev_d;
      frame_tick_q <= frame_tick_d;
      map_addr_q   <= map_addr_d;
      spr_addr_q   <= spr_addr_d;
      tx1_q        <= tx1_d;
      ty1_q        <= ty1_d;
      hit1_q       <= hit1_d;
      blank1_q     <= blank1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      tx2_q        <= tx2_d;
      ty2_q        <= ty2_d;
      hit2_q       <= hit2_d;
      blank2_q     <= blank2_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      tile_addr_q  <= tile_addr_d;
      spr3_q       <= spr3_d;
      hit3_q       <= hit3_d;
      blank3_q     <= blank3_d;
      hs3_q        <= hs3_d;
      vs3_q        <= vs3_d;
      spr4_q       <= spr4_d;
      hit4_q       <= hit4_d;
      blank4_q     <= blank4_d;
      hs4_q        <= hs4_d;
      vs4_q        <= vs4_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  assign map_addr   = map_addr_q;
  assign spr_addr   = spr_addr_q;
  assign tile_addr  = tile_addr_q;
  assign frame_tick = frame_tick_q;
  assign r          = rgb_q[11:8];
  assign g          = rgb_q[7:4];
  assign b          = rgb_q[3:0];
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomized bench for vga_pixel_pipe with a pixel-level reference
// model built from coordinates, tile grid and sprite rectangle.
module tb_vga_pixel_pipe;

  logic        vga_clk, clrn;
  logic [9:0]  col_in, row_in;
  logic        in_screen, hsync_in, vsync_in;
  logic [9:0]  spr_x, spr_y;
  logic [1:0]  spr_frame;
  logic        spr_en;
  logic [8:0]  map_addr;
  logic [5:0]  map_data;
  logic [15:0] tile_addr;
  logic [11:0] tile_data;
  logic [11:0] spr_addr;
  logic [11:0] spr_data;
  logic [3:0]  r, g, b;
  logic        hsync, vsync, frame_tick;

  vga_pixel_pipe dut (
    .vga_clk(vga_clk), .clrn(clrn),
    .col_in(col_in), .row_in(row_in), .in_screen(in_screen),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .spr_x(spr_x), .spr_y(spr_y), .spr_frame(spr_frame),
    .spr_en(spr_en),
    .map_addr(map_addr), .map_data(map_data),
    .tile_addr(tile_addr), .tile_data(tile_data),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [5:0]  map_mem  [512];
  logic [11:0] tile_mem [65536];
  logic [11:0] spr_mem  [4096];

  always @(posedge vga_clk) begin
    map_data  <= map_mem[map_addr];
    tile_data <= tile_mem[tile_addr];
    spr_data  <= spr_mem[spr_addr];
  end

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  // reference model state: sprite rectangle latched on vsync rise
  int m_sx, m_sy, m_fr;
  bit m_en, m_prev;
  logic [13:0] exp_q [$];

  function automatic logic [11:0] ref_pix(int c, int rr, bit ins);
    int id;
    logic [11:0] t, s;
    if (!ins) return 12'h000;
    id = int'(map_mem[(rr / 32) * 25 + c / 32]);
    t  = tile_mem[id * 1024 + (rr % 32) * 32 + c % 32];
    if (m_en && c >= m_sx && c < m_sx + 32 &&
        rr >= m_sy && rr < m_sy + 32) begin
      s = spr_mem[m_fr * 1024 + (rr - m_sy) * 32 + (c - m_sx)];
      if (s != 12'hF0F) return s;
    end
    return t;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(14'd0);
    m_sx = 0; m_sy = 0; m_fr = 0; m_en = 0; m_prev = 0;
  endfunction

  task automatic drive_pix(int c, int rr, bit ins, bit hs, bit vs);
    logic [13:0] e;
    col_in = 10'(c); row_in = 10'(rr);
    in_screen = ins; hsync_in = hs; vsync_in = vs;
    exp_q.push_back({ref_pix(c, rr, ins), hs, vs});
    if (vs && !m_prev) begin
      m_sx = int'(spr_x); m_sy = int'(spr_y);
      m_fr = int'(spr_frame); m_en = spr_en;
    end
    m_prev = vs;
    @(posedge vga_clk); #1;
    cyc++;
    e = exp_q.pop_front();
    nchk++;
    if ({r, g, b, hsync, vsync} !== e) begin
      nerr++;
      $display("FAIL pixel cyc=%0d got=%h expected=%h",
               cyc, {r, g, b, hsync, vsync}, e);
    end
  endtask

  task automatic flush(int n);
    for (int i = 0; i < n; i++) drive_pix(0, 0, 0, 1, 1);
  endtask

  task automatic latch(int x, int y, int f, bit en);
    drive_pix(0, 0, 0, 1, 0);
    drive_pix(0, 0, 0, 1, 0);
    spr_x = 10'(x); spr_y = 10'(y);
    spr_frame = 2'(f); spr_en = en;
    drive_pix(0, 0, 0, 1, 1);
    nchk++;
    if (frame_tick !== 1'b1) begin
      nerr++;
      $display("FAIL frame_tick_rise got=%b expected=1", frame_tick);
    end
    drive_pix(0, 0, 0, 1, 1);
    nchk++;
    if (frame_tick !== 1'b0) begin
      nerr++;
      $display("FAIL frame_tick_width got=%b expected=0", frame_tick);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      col_in = 10'($urandom); row_in = 10'($urandom);
      in_screen = 1'($urandom); hsync_in = 1'($urandom);
      vsync_in = 1'($urandom); spr_x = 10'($urandom);
      spr_y = 10'($urandom); spr_frame = 2'($urandom);
      spr_en = 1'($urandom);
      @(posedge vga_clk); #1;
      nchk++;
      if ({r, g, b, hsync, vsync, map_addr, tile_addr,
           spr_addr, frame_tick} !== 53'd0) begin
        nerr++;
        $display("FAIL reset_outputs got=%h expected=0",
                 {r, g, b, hsync, vsync, map_addr, tile_addr,
                  spr_addr, frame_tick});
      end
    end
    spr_en = 1'b0;
    model_reset();
    clrn = 1'b1;
    for (int i = 0; i < 10; i++)
      drive_pix($urandom_range(0, 799), $urandom_range(0, 599), 0, 1, 1);
  endtask

  task automatic test_tile_latency();
    logic [11:0] want;
    latch(0, 0, 0, 0);
    flush(5);
    map_mem[0] = 6'd5;
    tile_mem[16'h1400] = 12'h123;
    drive_pix(799, 599, 1, 1, 1);
    nchk++;
    if (map_addr !== 9'd474) begin
      nerr++;
      $display("FAIL map_corner got=%0d expected=474", map_addr);
    end
    drive_pix(0, 0, 1, 1, 1);
    nchk++;
    if (map_addr !== 9'd0) begin
      nerr++;
      $display("FAIL map_origin got=%0d expected=0", map_addr);
    end
    drive_pix(0, 0, 1, 1, 1);
    nchk++;
    if (tile_addr !== {map_mem[474], 5'd23, 5'd31}) begin
      nerr++;
      $display("FAIL tile_corner got=%h expected=%h",
               tile_addr, {map_mem[474], 5'd23, 5'd31});
    end
    drive_pix(0, 0, 1, 1, 1);
    nchk++;
    if (tile_addr !== 16'h1400) begin
      nerr++;
      $display("FAIL tile_latency got=%h expected=1400", tile_addr);
    end
    drive_pix(0, 0, 1, 1, 1);
    drive_pix(0, 0, 0, 1, 1);
    want = 12'h123;
    nchk++;
    if ({r, g, b} !== want) begin
      nerr++;
      $display("FAIL rgb_latency got=%h expected=%h", {r, g, b}, want);
    end
    nchk++;
    if ({map_addr, spr_addr} !== 21'd0) begin
      nerr++;
      $display("FAIL blank_addr got=%h expected=0", {map_addr, spr_addr});
    end
    flush(5);
  endtask

  task automatic test_sprite();
    logic [11:0] want;
    flush(5);
    spr_mem[12'h800] = 12'h0A0;
    latch(100, 50, 2, 1);
    drive_pix(100, 50, 1, 1, 1);
    nchk++;
    if (spr_addr !== 12'h800) begin
      nerr++;
      $display("FAIL spr_addr got=%h expected=800", spr_addr);
    end
    flush(4);
    want = 12'h0A0;
    nchk++;
    if ({r, g, b} !== want) begin
      nerr++;
      $display("FAIL sprite_opaque got=%h expected=%h", {r, g, b}, want);
    end
    flush(1);
    spr_mem[12'h800] = 12'hF0F;
    drive_pix(100, 50, 1, 1, 1);
    flush(4);
    want = tile_mem[int'(map_mem[28]) * 1024 + 18 * 32 + 4];
    nchk++;
    if ({r, g, b} !== want) begin
      nerr++;
      $display("FAIL sprite_key got=%h expected=%h", {r, g, b}, want);
    end
    flush(1);
    spr_mem[12'h800] = 12'h0A0;
    spr_x = 10'd300;
    drive_pix(100, 50, 1, 1, 1);
    flush(4);
    want = 12'h0A0;
    nchk++;
    if ({r, g, b} !== want) begin
      nerr++;
      $display("FAIL sprite_hold got=%h expected=%h", {r, g, b}, want);
    end
    for (int c = 90; c < 320; c++) drive_pix(c, 50, 1, 1, 1);
    latch(300, 50, 2, 1);
    drive_pix(300, 50, 1, 1, 1);
    flush(4);
    nchk++;
    if ({r, g, b} !== want) begin
      nerr++;
      $display("FAIL sprite_move got=%h expected=%h", {r, g, b}, want);
    end
    flush(5);
  endtask

  task automatic test_clip();
    logic [11:0] want;
    spr_mem[1321] = 12'h5A5;
    latch(790, 590, 1, 1);
    drive_pix(799, 599, 1, 1, 1);
    nchk++;
    if (spr_addr !== 12'h529) begin
      nerr++;
      $display("FAIL clip_addr got=%h expected=529", spr_addr);
    end
    flush(4);
    want = 12'h5A5;
    nchk++;
    if ({r, g, b} !== want) begin
      nerr++;
      $display("FAIL clip_hit got=%h expected=%h", {r, g, b}, want);
    end
    for (int rr = 588; rr < 600; rr++)
      for (int c = 780; c < 800; c++) drive_pix(c, rr, 1, 1, 1);
    for (int rr = 0; rr < 2; rr++)
      for (int c = 0; c < 22; c++) drive_pix(c, rr, 1, 1, 1);
    latch(1000, 100, 0, 1);
    for (int i = 0; i < 600; i++)
      drive_pix($urandom_range(760, 799), $urandom_range(90, 140),
                1, 1, 1);
    flush(5);
  endtask

  task automatic test_random();
    int x, y, c, rr;
    for (int k = 0; k < 8; k++) begin
      x = $urandom_range(0, 830);
      y = $urandom_range(0, 620);
      latch(x, y, $urandom_range(0, 3), $urandom_range(0, 7) != 0);
      for (int i = 0; i < 800; i++) begin
        c  = x - 8 + $urandom_range(0, 48);
        rr = y - 8 + $urandom_range(0, 48);
        if (c < 0) c = 0;
        if (c > 799) c = 799;
        if (rr < 0) rr = 0;
        if (rr > 599) rr = 599;
        drive_pix(c, rr, $urandom_range(0, 9) != 0, 1, 1);
      end
    end
    flush(5);
  endtask

  task automatic test_sync_frame();
    int rows [14] = '{598, 599, 600, 636, 637, 638, 639,
                      640, 641, 642, 643, 665, 0, 1};
    spr_x = 10'd10; spr_y = 10'd0;
    spr_frame = 2'd3; spr_en = 1'b1;
    foreach (rows[i])
      for (int c = 0; c < 1040; c++)
        drive_pix(c, rows[i], c < 800 && rows[i] < 600,
                  !(c >= 856 && c < 976),
                  !(rows[i] >= 637 && rows[i] < 643));
    flush(5);
  endtask

  task automatic test_reset_midframe();
    spr_mem[12'h800] = 12'h0A0;
    latch(100, 50, 2, 1);
    for (int c = 96; c < 104; c++) drive_pix(c, 50, 1, 1, 1);
    #2 clrn = 1'b0;
    #1;
    nchk++;
    if ({r, g, b, hsync, vsync, map_addr, tile_addr,
         spr_addr, frame_tick} !== 53'd0) begin
      nerr++;
      $display("FAIL midframe_reset got=%h expected=0",
               {r, g, b, hsync, vsync, map_addr, tile_addr,
                spr_addr, frame_tick});
    end
    @(posedge vga_clk); #1;
    model_reset();
    clrn = 1'b1;
    for (int c = 96; c < 140; c++) drive_pix(c, 50, 1, 1, 0);
    drive_pix(0, 0, 0, 1, 1);
    for (int c = 96; c < 140; c++) drive_pix(c, 50, 1, 1, 1);
    flush(5);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) map_mem[i] = 6'($urandom);
    for (int i = 0; i < 65536; i++) tile_mem[i] = 12'($urandom);
    for (int i = 0; i < 4096; i++)
      spr_mem[i] = ($urandom_range(0, 3) == 0) ? 12'hF0F
                                               : 12'($urandom);
    map_data = '0; tile_data = '0; spr_data = '0;
    col_in = '0; row_in = '0; in_screen = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    spr_x = '0; spr_y = '0; spr_frame = '0; spr_en = 1'b0;
    clrn = 1'b0;
    test_reset();
    test_tile_latency();
    test_sprite();
    test_clip();
    test_random();
    test_sync_frame();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
